// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer for the 8-bit ALU + register-file datapath.
// Takes 8085-style opcodes (plus an immediate byte for MVI) and sequences DEC/RD/WB control.
module exec_sequencer #(
  parameter int DATASIZE = 8,
  parameter int REGADDR  = 3,
  parameter int ACCADDR  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ivld,
  output logic                irdy,
  input  logic [DATASIZE-1:0] idat,
  output logic [DATASIZE-1:0] imm,
  output logic [REGADDR-1:0]  r1add,
  output logic [REGADDR-1:0]  r2add,
  output logic                r1enb,
  output logic                r2enb,
  output logic [REGADDR-1:0]  waddr,
  output logic                wrenb,
  output logic                flenb,
  output logic                fkeepc,
  output logic [3:0]          aluop,
  output logic [1:0]          wsrc,
  output logic                done,
  output logic                ill,
  output logic                halt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEC,
    S_IMM,
    S_RD,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_NOP,
    K_HLT,
    K_MOV,
    K_ALU,
    K_INR,
    K_DCR,
    K_MVI,
    K_ILL
  } kind_t;

  localparam logic [REGADDR-1:0] ACC      = REGADDR'(ACCADDR);
  localparam logic [2:0]         M_OPND   = 3'b110;
  localparam logic [1:0]         WSRC_ALU = 2'b00;
  localparam logic [1:0]         WSRC_IMM = 2'b01;
  localparam logic [1:0]         WSRC_R1  = 2'b10;

  state_t              state;
  state_t              state_nx;
  kind_t               kind;
  logic [DATASIZE-1:0] op;
  logic [DATASIZE-1:0] imm_q;
  logic [2:0]          ddd;
  logic [2:0]          sss;
  logic                xfer;

  assign ddd  = op[5:3];
  assign sss  = op[2:0];
  assign xfer = ivld && irdy;
  assign imm  = imm_q;

  // Instruction classification from the latched opcode; anything touching
  // the memory operand (M) or outside the supported subset is illegal.
  always_comb begin
    kind = K_ILL;
    case (op[7:6])
      2'b00: begin
        if (op == '0) begin
          kind = K_NOP;
        end else if (ddd != M_OPND) begin
          case (sss)
            3'b100:  kind = K_INR;
            3'b101:  kind = K_DCR;
            3'b110:  kind = K_MVI;
            default: kind = K_ILL;
          endcase
        end
      end
      2'b01: begin
        if (op == DATASIZE'(8'h76)) begin
          kind = K_HLT;
        end else if (ddd != M_OPND && sss != M_OPND) begin
          kind = K_MOV;
        end
      end
      2'b10: begin
        if (sss != M_OPND) begin
          kind = K_ALU;
        end
      end
      default: kind = K_ILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op    <= '0;
      imm_q <= '0;
    end else begin
      state <= state_nx;
      if (xfer && state == S_IDLE) begin
        op <= idat;
      end
      if (xfer && state == S_IMM) begin
        imm_q <= idat;
      end
    end
  end

  // NOTE: every output and next-state value gets a default before the case,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    irdy     = 1'b0;
    halt     = 1'b0;
    done     = 1'b0;
    ill      = 1'b0;
    r1add    = '0;
    r2add    = '0;
    r1enb    = 1'b0;
    r2enb    = 1'b0;
    waddr    = '0;
    wrenb    = 1'b0;
    flenb    = 1'b0;
    fkeepc   = 1'b0;
    aluop    = 4'b0000;
    wsrc     = WSRC_ALU;

    case (state)
      S_IDLE: begin
        irdy = 1'b1;
        if (xfer) begin
          state_nx = S_DEC;
        end
      end

      S_DEC: begin
        case (kind)
          K_NOP: begin
            done     = 1'b1;
            state_nx = S_IDLE;
          end
          K_HLT:   state_nx = S_HALT;
          K_MVI:   state_nx = S_IMM;
          K_ILL: begin
            ill      = 1'b1;
            state_nx = S_IDLE;
          end
          default: state_nx = S_RD;
        endcase
      end

      S_IMM: begin
        irdy = 1'b1;
        if (xfer) begin
          state_nx = S_WB;
        end
      end

      S_RD:    state_nx = S_WB;

      S_WB: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end

      S_HALT: begin
        halt     = 1'b1;
        state_nx = S_HALT;
      end

      default: state_nx = S_IDLE;
    endcase

    // Read ports are held through write-back so the datapath sees stable operands.
    if (state == S_RD || state == S_WB) begin
      case (kind)
        K_MOV: begin
          r1add = REGADDR'(sss);
          r1enb = 1'b1;
        end
        K_ALU: begin
          r1add = ACC;
          r2add = REGADDR'(sss);
          r1enb = 1'b1;
          r2enb = 1'b1;
        end
        K_INR, K_DCR: begin
          r1add = REGADDR'(ddd);
          r1enb = 1'b1;
        end
        default: ;
      endcase
    end

    if (state == S_WB) begin
      case (kind)
        K_MOV: begin
          waddr = REGADDR'(ddd);
          wrenb = 1'b1;
          wsrc  = WSRC_R1;
        end
        K_MVI: begin
          waddr = REGADDR'(ddd);
          wrenb = 1'b1;
          wsrc  = WSRC_IMM;
        end
        K_ALU: begin
          aluop = {1'b0, ddd};
          flenb = 1'b1;
          waddr = ACC;
          wsrc  = WSRC_ALU;
          // CMP only updates flags; the accumulator is left untouched.
          wrenb = (ddd != 3'b111);
        end
        K_INR, K_DCR: begin
          aluop  = (kind == K_INR) ? 4'b1000 : 4'b1001;
          flenb  = 1'b1;
          fkeepc = 1'b1;
          waddr  = REGADDR'(ddd);
          wrenb  = 1'b1;
          wsrc   = WSRC_ALU;
        end
        default: ;
      endcase
    end
  end

endmodule
